// File: rtl/ascon_seq_ctrl.sv
// Host-side sequencer for the serial Ascon core.
// Holds the operand bank and streams a snapshot of it to the core lane-serially.
// Then deserialises the core's output data and tag into parallel registers.
module ascon_seq_ctrl #(
  parameter int unsigned DW   = 128,
  parameter int unsigned LANE = 3,
  parameter int unsigned TMO  = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [3:0]      wr_addr,
  input  logic [31:0]     wr_data,
  input  logic            cmd_go,
  input  logic            cmd_dec,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [DW-1:0]   dout,
  output logic [DW-1:0]   tag,
  output logic [LANE-1:0] key_o,
  output logic [LANE-1:0] nonce_o,
  output logic [LANE-1:0] ad_o,
  output logic [LANE-1:0] din_o,
  output logic            start_o,
  output logic            dec_o,
  input  logic            out_i,
  input  logic            tag_i,
  input  logic            rdy_i
);

  localparam int unsigned NB = (DW + LANE - 1) / LANE;
  localparam int unsigned PW = NB * LANE;
  localparam int unsigned BW = $clog2(NB + 1);
  localparam int unsigned CW = $clog2(DW + 1);
  localparam int unsigned TW = $clog2(TMO + 1);

  localparam logic [BW-1:0] BeatLast = BW'(NB - 1);
  localparam logic [CW-1:0] CaptLast = CW'(DW - 1);
  localparam logic [TW-1:0] TmoLast  = TW'(TMO - 1);

  typedef enum logic [2:0] {StIdle, StStart, StFeed, StWait, StCapt} state_e;

  state_e          r_state, w_state_d;
  logic [DW-1:0]   r_key, r_nonce, r_ad, r_din;
  logic [DW-1:0]   w_key_d, w_nonce_d, w_ad_d, w_din_d;
  // Snapshot shift registers, operand left-aligned with zero padding below bit 0
  logic [PW-1:0]   r_sh_key, r_sh_nonce, r_sh_ad, r_sh_din;
  logic [PW-1:0]   w_sh_key_d, w_sh_nonce_d, w_sh_ad_d, w_sh_din_d;
  logic [BW-1:0]   r_beat, w_beat_d;
  logic [CW-1:0]   r_cnt, w_cnt_d;
  logic [TW-1:0]   r_tmo, w_tmo_d;
  logic            r_busy, r_done, r_err, r_start, r_dec;
  logic            w_busy_d, w_done_d, w_err_d, w_start_d, w_dec_d;
  logic [LANE-1:0] r_key_l, r_nonce_l, r_ad_l, r_din_l;
  logic [LANE-1:0] w_key_l_d, w_nonce_l_d, w_ad_l_d, w_din_l_d;
  logic [DW-1:0]   r_dout, r_tag, w_dout_d, w_tag_d;
  int unsigned     w_wr_msb;

  // Bit index of the most significant bit of the addressed 32-bit word
  assign w_wr_msb = DW - 1 - 32 * int'(wr_addr[1:0]);

  // Next-state, bank update, serialisation and capture
  always_comb begin
    w_state_d    = r_state;
    w_key_d      = r_key;
    w_nonce_d    = r_nonce;
    w_ad_d       = r_ad;
    w_din_d      = r_din;
    w_sh_key_d   = r_sh_key;
    w_sh_nonce_d = r_sh_nonce;
    w_sh_ad_d    = r_sh_ad;
    w_sh_din_d   = r_sh_din;
    w_beat_d     = r_beat;
    w_cnt_d      = r_cnt;
    w_tmo_d      = r_tmo;
    w_done_d     = 1'b0;
    w_start_d    = 1'b0;
    w_err_d      = r_err;
    w_dec_d      = r_dec;
    w_key_l_d    = '0;
    w_nonce_l_d  = '0;
    w_ad_l_d     = '0;
    w_din_l_d    = '0;
    w_dout_d     = r_dout;
    w_tag_d      = r_tag;

    unique case (r_state)
      StIdle: begin
        if (wr_en) begin
          unique case (wr_addr[3:2])
            2'd0: w_key_d[w_wr_msb -: 32]   = wr_data;
            2'd1: w_nonce_d[w_wr_msb -: 32] = wr_data;
            2'd2: w_ad_d[w_wr_msb -: 32]    = wr_data;
            2'd3: w_din_d[w_wr_msb -: 32]   = wr_data;
            default: ;
          endcase
        end
        if (cmd_go) begin
          // Snapshot takes the pre-write bank so a same-cycle write affects only later runs
          w_sh_key_d   = PW'(r_key) << (PW - DW);
          w_sh_nonce_d = PW'(r_nonce) << (PW - DW);
          w_sh_ad_d    = PW'(r_ad) << (PW - DW);
          w_sh_din_d   = PW'(r_din) << (PW - DW);
          w_dec_d      = cmd_dec;
          w_err_d      = 1'b0;
          w_start_d    = 1'b1;
          w_state_d    = StStart;
        end
      end
      StStart: begin
        w_key_l_d    = r_sh_key[PW-1 -: LANE];
        w_nonce_l_d  = r_sh_nonce[PW-1 -: LANE];
        w_ad_l_d     = r_sh_ad[PW-1 -: LANE];
        w_din_l_d    = r_sh_din[PW-1 -: LANE];
        w_sh_key_d   = r_sh_key << LANE;
        w_sh_nonce_d = r_sh_nonce << LANE;
        w_sh_ad_d    = r_sh_ad << LANE;
        w_sh_din_d   = r_sh_din << LANE;
        w_beat_d     = '0;
        w_state_d    = StFeed;
      end
      StFeed: begin
        // r_beat is the beat currently on the lanes
        if (r_beat == BeatLast) begin
          w_tmo_d   = '0;
          w_state_d = StWait;
        end else begin
          w_key_l_d    = r_sh_key[PW-1 -: LANE];
          w_nonce_l_d  = r_sh_nonce[PW-1 -: LANE];
          w_ad_l_d     = r_sh_ad[PW-1 -: LANE];
          w_din_l_d    = r_sh_din[PW-1 -: LANE];
          w_sh_key_d   = r_sh_key << LANE;
          w_sh_nonce_d = r_sh_nonce << LANE;
          w_sh_ad_d    = r_sh_ad << LANE;
          w_sh_din_d   = r_sh_din << LANE;
          w_beat_d     = r_beat + 1'b1;
        end
      end
      StWait: begin
        if (rdy_i) begin
          w_dout_d  = {r_dout[DW-2:0], out_i};
          w_tag_d   = {r_tag[DW-2:0], tag_i};
          w_cnt_d   = CW'(1);
          w_state_d = StCapt;
        end else if (r_tmo == TmoLast) begin
          w_err_d   = 1'b1;
          w_state_d = StIdle;
        end else begin
          w_tmo_d = r_tmo + 1'b1;
        end
      end
      StCapt: begin
        w_dout_d = {r_dout[DW-2:0], out_i};
        w_tag_d  = {r_tag[DW-2:0], tag_i};
        if (r_cnt == CaptLast) begin
          w_done_d  = 1'b1;
          w_state_d = StIdle;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase

    w_busy_d = (w_state_d != StIdle);
  end

  // State, bank and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_key      <= '0;
      r_nonce    <= '0;
      r_ad       <= '0;
      r_din      <= '0;
      r_sh_key   <= '0;
      r_sh_nonce <= '0;
      r_sh_ad    <= '0;
      r_sh_din   <= '0;
      r_beat     <= '0;
      r_cnt      <= '0;
      r_tmo      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_start    <= 1'b0;
      r_dec      <= 1'b0;
      r_key_l    <= '0;
      r_nonce_l  <= '0;
      r_ad_l     <= '0;
      r_din_l    <= '0;
      r_dout     <= '0;
      r_tag      <= '0;
    end else begin
      r_state    <= w_state_d;
      r_key      <= w_key_d;
      r_nonce    <= w_nonce_d;
      r_ad       <= w_ad_d;
      r_din      <= w_din_d;
      r_sh_key   <= w_sh_key_d;
      r_sh_nonce <= w_sh_nonce_d;
      r_sh_ad    <= w_sh_ad_d;
      r_sh_din   <= w_sh_din_d;
      r_beat     <= w_beat_d;
      r_cnt      <= w_cnt_d;
      r_tmo      <= w_tmo_d;
      r_busy     <= w_busy_d;
      r_done     <= w_done_d;
      r_err      <= w_err_d;
      r_start    <= w_start_d;
      r_dec      <= w_dec_d;
      r_key_l    <= w_key_l_d;
      r_nonce_l  <= w_nonce_l_d;
      r_ad_l     <= w_ad_l_d;
      r_din_l    <= w_din_l_d;
      r_dout     <= w_dout_d;
      r_tag      <= w_tag_d;
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;
  assign start_o = r_start;
  assign dec_o   = r_dec;
  assign key_o   = r_key_l;
  assign nonce_o = r_nonce_l;
  assign ad_o    = r_ad_l;
  assign din_o   = r_din_l;
  assign dout    = r_dout;
  assign tag     = r_tag;

endmodule

// File: tb/tb_ascon_seq_ctrl.sv
// Directed bench for ascon_seq_ctrl (TMO shortened to 16 for the timeout run).
module tb_ascon_seq_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic [3:0]   wr_addr;
  logic [31:0]  wr_data;
  logic         cmd_go, cmd_dec;
  logic         busy, done, err;
  logic [127:0] dout, tag;
  logic [2:0]   key_o, nonce_o, ad_o, din_o;
  logic         start_o, dec_o;
  logic         out_i, tag_i, rdy_i;

  int checks = 0;
  int errors = 0;
  int starts, dones;
  logic [127:0] pat;

  ascon_seq_ctrl #(.DW(128), .LANE(3), .TMO(16)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cmd_go(cmd_go), .cmd_dec(cmd_dec), .busy(busy), .done(done), .err(err),
    .dout(dout), .tag(tag), .key_o(key_o), .nonce_o(nonce_o), .ad_o(ad_o),
    .din_o(din_o), .start_o(start_o), .dec_o(dec_o), .out_i(out_i), .tag_i(tag_i),
    .rdy_i(rdy_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string t, input logic [127:0] o, input logic [127:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", t, o, e);
    end
  endtask

  // Advance to the next cycle; inputs set and outputs read 1 time unit after the edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; cmd_go = 1'b0; cmd_dec = 1'b0;
    out_i = 1'b0; tag_i = 1'b0; rdy_i = 1'b0;
    pat = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_lanes", {key_o, nonce_o, ad_o, din_o}, 12'h0);
    chk("rst_dout", dout, 128'h0);
    chk("rst_tag", tag, 128'h0);
    chk("rst_start_dec", {start_o, dec_o}, 2'b00);

    wr(4'h0, 32'h00010203); wr(4'h1, 32'h04050607);
    wr(4'h2, 32'h08090A0B); wr(4'h3, 32'h0C0D0E0F);
    wr(4'h4, 32'hFFFFFFFF); wr(4'h5, 32'hFFFFFFFF);
    wr(4'h6, 32'hFFFFFFFF); wr(4'h7, 32'hFFFFFFFF);
    wr(4'hC, 32'h80000000); wr(4'hF, 32'h00000001);

    // Run 1: serialisation and capture, decrypt, rdy at cycle 60
    cmd_dec = 1'b1; cmd_go = 1'b1;
    tick();                                   // cycle 1
    cmd_go = 1'b0; cmd_dec = 1'b0;
    chk("r1_start_c1", start_o, 1'b1);
    chk("r1_busy_c1", busy, 1'b1);
    chk("r1_lanes_c1", {key_o, nonce_o, ad_o, din_o}, 12'h0);
    tick();                                   // cycle 2
    chk("r1_b0_key", key_o, 3'd0);
    chk("r1_b0_nonce", nonce_o, 3'd7);
    chk("r1_b0_ad", ad_o, 3'd0);
    chk("r1_b0_din", din_o, 3'd4);
    chk("r1_dec", dec_o, 1'b1);
    starts = 0; dones = 0;
    for (int c = 2; c < 44; c++) begin
      if (start_o) starts++;
      tick();
    end                                       // cycle 44
    chk("r1_b42_key", key_o, 3'b110);
    chk("r1_b42_nonce", nonce_o, 3'b110);
    chk("r1_b42_din", din_o, 3'b010);
    chk("r1_no_extra_start", starts, 0);
    tick();                                   // cycle 45
    chk("r1_wait_lanes", {key_o, nonce_o, ad_o, din_o}, 12'h0);
    chk("r1_wait_busy", busy, 1'b1);
    for (int c = 45; c < 60; c++) begin
      if (done) dones++;
      tick();
    end                                       // cycle 60
    chk("r1_busy_c60", busy, 1'b1);
    rdy_i = 1'b1; out_i = pat[127]; tag_i = ~pat[127];
    for (int i = 1; i < 128; i++) begin
      tick();
      rdy_i = 1'b0; out_i = pat[127-i]; tag_i = ~pat[127-i];
      if (done) dones++;
    end                                       // cycle 187
    chk("r1_no_early_done", dones, 0);
    tick();                                   // cycle 188
    chk("r1_done_c188", done, 1'b1);
    chk("r1_busy_c188", busy, 1'b0);
    chk("r1_dout", dout, pat);
    chk("r1_tag", tag, ~pat);
    tick();
    chk("r1_done_pulse", done, 1'b0);

    // Run 2: timeout, rdy never asserted
    out_i = 1'b0; tag_i = 1'b0;
    cmd_go = 1'b1;
    tick();                                   // cycle 1
    cmd_go = 1'b0;
    chk("r2_dec", dec_o, 1'b0);
    dones = 0;
    for (int c = 1; c < 60; c++) begin
      if (done) dones++;
      tick();
    end                                       // cycle 60 = WAIT entry + 15
    chk("r2_busy_c60", busy, 1'b1);
    chk("r2_err_c60", err, 1'b0);
    tick();                                   // cycle 61
    chk("r2_err", err, 1'b1);
    chk("r2_busy", busy, 1'b0);
    chk("r2_done", {dones[0], done}, 2'b00);
    chk("r2_dout_kept", dout, pat);

    // Run 3: err cleared by go; write and go during FEED ignored
    cmd_go = 1'b1;
    tick();                                   // cycle 1
    cmd_go = 1'b0;
    chk("r3_err_clr", err, 1'b0);
    chk("r3_start", start_o, 1'b1);
    tick(); tick(); tick(); tick();           // cycle 5
    wr_en = 1'b1; wr_addr = 4'h0; wr_data = 32'hFFFFFFFF; cmd_go = 1'b1;
    tick();                                   // cycle 6
    wr_en = 1'b0; cmd_go = 1'b0;
    starts = 0; dones = 0;
    for (int c = 6; c < 45; c++) begin
      if (start_o) starts++;
      if (done) dones++;
      tick();
    end                                       // cycle 45
    rdy_i = 1'b1; out_i = 1'b1; tag_i = 1'b0;
    for (int c = 45; c < 173; c++) begin
      if (start_o) starts++;
      if (done) dones++;
      tick();
      rdy_i = 1'b0;
    end                                       // cycle 173
    chk("r3_done_c173", done, 1'b1);
    chk("r3_dout", dout, {128{1'b1}});
    chk("r3_tag", tag, 128'h0);
    for (int c = 173; c < 186; c++) begin
      if (start_o) starts++;
      if (done) dones++;
      tick();
    end
    chk("r3_one_start", starts, 0);
    chk("r3_one_done", dones, 1);
    out_i = 1'b0;

    // Run 4: same-cycle write to din word 3 streams the old value
    wr_en = 1'b1; wr_addr = 4'hF; wr_data = 32'hFFFFFFFF; cmd_go = 1'b1;
    tick();                                   // cycle 1
    wr_en = 1'b0; cmd_go = 1'b0;
    tick();                                   // cycle 2
    chk("r4_key_unchanged", key_o, 3'd0);
    chk("r4_b0_din", din_o, 3'd4);
    for (int c = 2; c < 44; c++) tick();      // cycle 44
    chk("r4_b42_din_old", din_o, 3'b010);
    for (int c = 44; c < 61; c++) tick();     // cycle 61, timed out
    chk("r4_idle", busy, 1'b0);

    // Run 5: new din value streams; reset mid-FEED
    cmd_go = 1'b1;
    tick();
    cmd_go = 1'b0;
    tick();                                   // cycle 2
    chk("r5_b0_din", din_o, 3'd4);
    for (int c = 2; c < 44; c++) tick();      // cycle 44
    chk("r5_b42_din_new", din_o, 3'b110);
    chk("r5_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("r5_rst_busy", busy, 1'b0);
    chk("r5_rst_lanes", {key_o, nonce_o, ad_o, din_o}, 12'h0);
    chk("r5_rst_dout", dout, 128'h0);
    chk("r5_rst_tag", tag, 128'h0);
    chk("r5_rst_flags", {done, err, start_o, dec_o}, 4'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("r5_after_rst", {busy, done}, 2'b00);

    // Bank cleared by reset
    cmd_go = 1'b1;
    tick();
    cmd_go = 1'b0;
    tick();
    chk("r6_bank_cleared", {key_o, nonce_o, ad_o, din_o}, 12'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
